// File: rtl/mc_controller_if.sv
// Control bus between the SimpleARM multicycle controller and its datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave modport.
interface mc_controller_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       IRWrite;
   logic       AdrSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] ALUControl;
   logic       LinkSel;

   modport master (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, LinkSel
   );

   modport slave (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, LinkSel
   );
endinterface

// File: rtl/mc_controller.sv
// Multicycle SimpleARM control unit: instruction FSM, NZCV register, condition evaluation.
// Optional BL_SUPPORT_EN: BL writes the return address to R14 during BRANCH.
module mc_controller (
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q;
   logic       cond_ex, gate_ce;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic [3:0] cmd;
   logic [1:0] dp_alu;
   logic       cmd_known, is_arith, is_cmp, in_exec, flag_we;

   logic       ir_w, pc_w_fetch, pc_w_gated, reg_w_gated, mem_w_gated;
   logic       adr_src;
   logic [1:0] src_a, src_b, res_src, alu_ctl;
`ifdef BL_SUPPORT_EN
   logic       link_sel;
`endif

   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
   assign cmd     = bus.Funct[4:1];
   assign is_cmp  = (cmd == 4'b1010);
   assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

   always_comb begin
      unique case (bus.Cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = !flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = !flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = !flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = !flag_v;
         4'b1000: cond_ex = flag_c && !flag_z;
         4'b1001: cond_ex = !flag_c || flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
         4'b1101: cond_ex = flag_z || (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // ALUWB must see the instruction-start condition, not the flags EXEC just wrote.
   assign gate_ce = (state_q == S_ALUWB) ? cond_ex_q : cond_ex;

   // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      dp_alu    = 2'b00;
      cmd_known = 1'b1;
      is_arith  = 1'b0;
      unique case (cmd)
         4'b0100: is_arith = 1'b1;
         4'b0010: begin dp_alu = 2'b01; is_arith = 1'b1; end
         4'b0000: dp_alu = 2'b10;
         4'b1100: dp_alu = 2'b11;
         4'b1010: begin dp_alu = 2'b01; is_arith = 1'b1; end
         default: cmd_known = 1'b0;
      endcase
   end

   assign flag_we = in_exec && bus.Funct[0] && cond_ex && cmd_known;

   always_comb begin
      flags_d = flags_q;
      if (flag_we) begin
         flags_d[3:2] = bus.ALUFlags[3:2];
         if (is_arith) flags_d[1:0] = bus.ALUFlags[1:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            unique case (bus.Op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ir_w        = 1'b0;
      pc_w_fetch  = 1'b0;
      pc_w_gated  = 1'b0;
      reg_w_gated = 1'b0;
      mem_w_gated = 1'b0;
      adr_src     = 1'b0;
      src_a       = 2'b00;
      src_b       = 2'b00;
      res_src     = 2'b00;
      alu_ctl     = 2'b00;
`ifdef BL_SUPPORT_EN
      link_sel    = 1'b0;
`endif
      unique case (state_q)
         S_FETCH: begin
            ir_w       = 1'b1;
            pc_w_fetch = 1'b1;
            src_a      = 2'b01;
            src_b      = 2'b10;
            res_src    = 2'b10;
         end
         S_DECODE: begin
            src_a = 2'b01;
            src_b = 2'b10;
         end
         S_MEMADR: src_b = 2'b01;
         S_MEMRD:  adr_src = 1'b1;
         S_MEMWB: begin
            res_src     = 2'b01;
            reg_w_gated = 1'b1;
            pc_w_gated  = (bus.Rd == 4'd15);
         end
         S_MEMWR: begin
            adr_src     = 1'b1;
            mem_w_gated = 1'b1;
         end
         S_EXECR: alu_ctl = dp_alu;
         S_EXECI: begin
            src_b   = 2'b01;
            alu_ctl = dp_alu;
         end
         S_ALUWB: begin
            reg_w_gated = !is_cmp;
            pc_w_gated  = !is_cmp && (bus.Rd == 4'd15);
         end
         S_BRANCH: begin
            src_a      = 2'b10;
            src_b      = 2'b01;
            res_src    = 2'b10;
            pc_w_gated = 1'b1;
`ifdef BL_SUPPORT_EN
            reg_w_gated = bus.Funct[4];
            link_sel    = bus.Funct[4];
`endif
         end
         default: ;
      endcase
   end

   // Reset blanks every write enable so an interrupted instruction never commits.
   assign bus.IRWrite    = !reset && ir_w;
   assign bus.PCWrite    = !reset && (pc_w_fetch || (pc_w_gated && gate_ce));
   assign bus.RegWrite   = !reset && reg_w_gated && gate_ce;
   assign bus.MemWrite   = !reset && mem_w_gated && gate_ce;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ResultSrc  = res_src;
   assign bus.ALUControl = alu_ctl;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
`ifdef BL_SUPPORT_EN
   assign bus.LinkSel    = link_sel;
`else
   assign bus.LinkSel    = 1'b0;
`endif

endmodule
